// File: rtl/mem_arbiter_pkg.sv
// Shared types for the cache-to-memory arbiter: FSM states, requester IDs and
// the encoding of the last-served-read register.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        REQ_I   = 2'd0,
        REQ_DRD = 2'd1,
        REQ_DWR = 2'd2
    } req_id_t;

    // Encoding of last_rd: which read requester was granted most recently.
    localparam logic LAST_RD_I     = 1'b0;
    localparam logic LAST_RD_D     = 1'b1;
    localparam logic LAST_RD_RESET = LAST_RD_D;

    function automatic logic rd_id_to_last(input req_id_t id);
        return (id == REQ_DRD) ? LAST_RD_D : LAST_RD_I;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin selector between the icache and dcache read requesters;
// on a tie the requester that was not served last wins.
module rr_pick2
    import mem_arbiter_pkg::*;
(
    input  logic i_req_ic,
    input  logic i_req_dc,
    input  logic i_last_rd,
    output logic o_any,
    output logic o_pick_dc
);

    // NOTE: every combinational output gets a default first so no latch can be inferred.
    always_comb begin
        o_any     = i_req_ic | i_req_dc;
        o_pick_dc = i_req_dc;
        if (i_req_ic && i_req_dc) begin
            o_pick_dc = (i_last_rd == LAST_RD_I);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: one outstanding transaction, write-back first,
// then round-robin between icache reads and dcache refills.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_rd_req,
    input  logic [ADDR_W-1:0] d_rd_addr,
    output logic              d_rd_ack,
    output logic [DATA_W-1:0] d_rdata,
    input  logic              d_wr_req,
    input  logic [ADDR_W-1:0] d_wr_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_wr_ack,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_ack,
    input  logic [DATA_W-1:0] m_rdata
);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    req_id_t           r_grant;
    req_id_t           w_grant_nxt;
    logic              r_last_rd;
    logic              r_holdoff;
    logic              r_m_we;
    logic [ADDR_W-1:0] r_m_addr;
    logic [DATA_W-1:0] r_m_wdata;
    logic [DATA_W-1:0] r_i_rdata;
    logic [DATA_W-1:0] r_d_rdata;
    logic              w_rd_any;
    logic              w_pick_dc;
    logic              w_grant_fire;

    rr_pick2 u_rr_pick2 (
        .i_req_ic  (i_req),
        .i_req_dc  (d_rd_req),
        .i_last_rd (r_last_rd),
        .o_any     (w_rd_any),
        .o_pick_dc (w_pick_dc)
    );

    // The IDLE cycle straight after RESP never grants (r_holdoff), so a
    // requester still deasserting after its ack cannot be served twice.
    always_comb begin
        w_state_nxt  = r_state;
        w_grant_nxt  = r_grant;
        w_grant_fire = 1'b0;
        m_req        = 1'b0;
        i_ack        = 1'b0;
        d_rd_ack     = 1'b0;
        d_wr_ack     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!r_holdoff && (d_wr_req || w_rd_any)) begin
                    w_grant_fire = 1'b1;
                    w_state_nxt  = ST_BUSY;
                    if (d_wr_req) begin
                        w_grant_nxt = REQ_DWR;
                    end else if (w_pick_dc) begin
                        w_grant_nxt = REQ_DRD;
                    end else begin
                        w_grant_nxt = REQ_I;
                    end
                end
            end
            ST_BUSY: begin
                m_req = 1'b1;
                if (m_ack) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
                case (r_grant)
                    REQ_I:   i_ack    = 1'b1;
                    REQ_DRD: d_rd_ack = 1'b1;
                    REQ_DWR: d_wr_ack = 1'b1;
                    default: ;
                endcase
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_grant   <= REQ_I;
            r_holdoff <= 1'b0;
            r_last_rd <= LAST_RD_RESET;
        end else begin
            r_state   <= w_state_nxt;
            r_grant   <= w_grant_nxt;
            r_holdoff <= (r_state == ST_RESP);
            if (w_grant_fire && (w_grant_nxt != REQ_DWR)) begin
                r_last_rd <= rd_id_to_last(w_grant_nxt);
            end
        end
    end

    // Request fields are frozen at grant; read data lands in the per-port
    // register on m_ack and is held until that port's next capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m_we    <= 1'b0;
            r_m_addr  <= '0;
            r_m_wdata <= '0;
            r_i_rdata <= '0;
            r_d_rdata <= '0;
        end else begin
            if (w_grant_fire) begin
                r_m_we <= (w_grant_nxt == REQ_DWR);
                case (w_grant_nxt)
                    REQ_DWR: begin
                        r_m_addr  <= d_wr_addr;
                        r_m_wdata <= d_wdata;
                    end
                    REQ_DRD: begin
                        r_m_addr  <= d_rd_addr;
                        r_m_wdata <= '0;
                    end
                    default: begin
                        r_m_addr  <= i_addr;
                        r_m_wdata <= '0;
                    end
                endcase
            end
            if ((r_state == ST_BUSY) && m_ack) begin
                if (r_grant == REQ_I) begin
                    r_i_rdata <= m_rdata;
                end else if (r_grant == REQ_DRD) begin
                    r_d_rdata <= m_rdata;
                end
            end
        end
    end

    assign m_we    = r_m_we;
    assign m_addr  = r_m_addr;
    assign m_wdata = r_m_wdata;
    assign i_rdata = r_i_rdata;
    assign d_rdata = r_d_rdata;

endmodule
